// File: rtl/deserializer_8b_32b.sv
// rtl/deserializer_8b_32b.sv - byte-to-word deserializer with idle-byte sync FSM
module deserializer_8b_32b #(
  parameter logic [7:0] IDLE_BYTE  = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         LOSS_COUNT = 2
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        err_partial
);

  // Counter widths sized so each counter can hold its own threshold.
  localparam int IW = $clog2(SYNC_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  localparam logic [IW-1:0] IDLE_LAST = IW'(SYNC_COUNT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(SYNC_COUNT);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_COUNT - 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_SYNC   = 1'b1;

  logic [0:0]    state_q,       state_d;
  logic [IW-1:0] idle_cnt_q,    idle_cnt_d;
  logic [BW-1:0] bad_cnt_q,     bad_cnt_d;
  logic [1:0]    byte_cnt_q,    byte_cnt_d;
  logic [31:0]   word_buf_q,    word_buf_d;
  logic [31:0]   data_out_q,    data_out_d;
  logic          valid_out_q,   valid_out_d;
  logic          err_partial_q, err_partial_d;

  logic          is_idle;
  logic          is_bad;

  // Classify the incoming byte: idle fill, payload, or corrupted non-idle.
  always_comb begin
    is_idle = 1'b0;
    is_bad  = 1'b0;
    if (!valid_in) begin
      is_idle = (data_in == IDLE_BYTE);
      is_bad  = (data_in != IDLE_BYTE);
    end
  end

  // Next-state logic: sync search, word assembly, truncation and loss detection.
  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    word_buf_d    = word_buf_q;
    data_out_d    = data_out_q;
    valid_out_d   = 1'b0;
    err_partial_d = 1'b0;

    if (state_q == ST_SEARCH) begin
      // Payload bytes are ignored here; only a run of idles re-aligns the link.
      if (is_idle) begin
        if (idle_cnt_q >= IDLE_LAST) begin
          state_d    = ST_SYNC;
          idle_cnt_d = IDLE_MAX;
          byte_cnt_d = 2'd0;
          bad_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end else begin
        idle_cnt_d = '0;
      end
    end else begin
      if (valid_in) begin
        // MSB byte first: byte 0 lands in [31:24].
        case (byte_cnt_q)
          2'd0:    word_buf_d[31:24] = data_in;
          2'd1:    word_buf_d[23:16] = data_in;
          2'd2:    word_buf_d[15:8]  = data_in;
          default: word_buf_d[7:0]   = data_in;
        endcase
        if (byte_cnt_q == 2'd3) begin
          // Bypass the buffer for the last byte so the word leaves on this edge.
          data_out_d  = {word_buf_q[31:8], data_in};
          valid_out_d = 1'b1;
        end
        byte_cnt_d = byte_cnt_q + 2'd1;
        bad_cnt_d  = '0;
      end else begin
        // Any gap inside a word truncates it; data_out keeps the last good word.
        if (byte_cnt_q != 2'd0) begin
          byte_cnt_d    = 2'd0;
          err_partial_d = 1'b1;
        end
        if (is_idle) begin
          bad_cnt_d = '0;
        end else if (is_bad) begin
          if (bad_cnt_q >= BAD_LAST) begin
            state_d    = ST_SEARCH;
            idle_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + BW'(1);
          end
        end
      end
    end
  end

  // State and output registers; reset wins over every other event on the edge.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      idle_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      byte_cnt_q    <= 2'd0;
      word_buf_q    <= 32'd0;
      data_out_q    <= 32'd0;
      valid_out_q   <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      word_buf_q    <= word_buf_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      err_partial_q <= err_partial_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign active      = (state_q == ST_SYNC);
  assign err_partial = err_partial_q;

endmodule

// File: tb/tb_deserializer_8b_32b.sv
// tb/tb_deserializer_8b_32b.sv - self-checking bench for deserializer_8b_32b
module tb_deserializer_8b_32b;

  logic        clk_4f = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'hBC;
  logic        valid_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic        err_partial;

  int n_vec = 0;
  int n_err = 0;

  deserializer_8b_32b dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .err_partial (err_partial)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference model: link state plus a queue of the bytes of the word in flight.
  bit          m_started = 1'b0;
  bit          m_sync = 1'b0;
  int          m_idle_run = 0;
  int          m_bad_run = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] exp_data = 32'd0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_active = 1'b0;

  always @(posedge clk_4f) begin
    bit idle;
    idle = !valid_in && (data_in == 8'hBC);
    exp_valid = 1'b0;
    exp_err = 1'b0;
    if (reset) begin
      m_started = 1'b1;
      m_sync = 1'b0;
      m_idle_run = 0;
      m_bad_run = 0;
      m_bytes.delete();
      exp_data = 32'd0;
    end else if (!m_sync) begin
      if (idle) begin
        m_idle_run++;
        if (m_idle_run >= 4) begin
          m_sync = 1'b1;
          m_bad_run = 0;
          m_bytes.delete();
        end
      end else begin
        m_idle_run = 0;
      end
    end else if (valid_in) begin
      m_bytes.push_back(data_in);
      m_bad_run = 0;
      if (m_bytes.size() == 4) begin
        exp_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        exp_valid = 1'b1;
        m_bytes.delete();
      end
    end else begin
      if (m_bytes.size() != 0) begin
        exp_err = 1'b1;
        m_bytes.delete();
      end
      if (idle) begin
        m_bad_run = 0;
      end else begin
        m_bad_run++;
        if (m_bad_run >= 2) begin
          m_sync = 1'b0;
          m_idle_run = 0;
        end
      end
    end
    exp_active = m_sync;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // One cycle: compare all outputs against the model, then drive the next byte.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk_4f);
    if (m_started) begin
      chk("data_out", data_out, exp_data);
      chk("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
      chk("active", {31'd0, active}, {31'd0, exp_active});
      chk("err_partial", {31'd0, err_partial}, {31'd0, exp_err});
    end
    reset = r;
    valid_in = v;
    data_in = d;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'hBC);
  endtask

  task automatic word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, t[8*i +: 8]);
  endtask

  // Sample just after the edge that consumed the last driven byte.
  task automatic after_edge();
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    // 1. Reset and sync acquisition
    step(1'b1, 1'b0, 8'hBC);
    step(1'b1, 1'b0, 8'hBC);
    after_edge();
    chk("rst_data", data_out, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    idles(3);
    after_edge();
    chk("pre_sync_active", {31'd0, active}, 32'd0);
    idles(1);
    after_edge();
    chk("sync_active", {31'd0, active}, 32'd1);
    chk("sync_valid", {31'd0, valid_out}, 32'd0);

    // 2. Back-to-back words, first byte on the cycle right after sync
    word(32'hFFFBBFFF);
    after_edge();
    chk("w1_data", data_out, 32'hFFFBBFFF);
    chk("w1_valid", {31'd0, valid_out}, 32'd1);
    word(32'hDDDDDDDD);
    after_edge();
    chk("w2_data", data_out, 32'hDDDDDDDD);
    chk("w2_valid", {31'd0, valid_out}, 32'd1);

    // 3. Truncated word
    step(1'b0, 1'b1, 8'hDD);
    step(1'b0, 1'b1, 8'h00);
    idles(1);
    after_edge();
    chk("trunc_err", {31'd0, err_partial}, 32'd1);
    chk("trunc_hold", data_out, 32'hDDDDDDDD);
    word(32'hDD000003);
    after_edge();
    chk("w3_data", data_out, 32'hDD000003);
    chk("w3_valid", {31'd0, valid_out}, 32'd1);

    // 4. Idle gap between words
    word(32'h12345678);
    idles(3);
    word(32'h9ABCDEF0);
    after_edge();
    chk("gap_data", data_out, 32'h9ABCDEF0);
    chk("gap_active", {31'd0, active}, 32'd1);

    // 5. Sync loss and reacquisition
    step(1'b0, 1'b0, 8'hAA);
    after_edge();
    chk("loss1_active", {31'd0, active}, 32'd1);
    step(1'b0, 1'b0, 8'hAA);
    after_edge();
    chk("loss2_active", {31'd0, active}, 32'd0);
    word(32'h11223344);
    after_edge();
    chk("search_valid", {31'd0, valid_out}, 32'd0);
    chk("search_hold", data_out, 32'h9ABCDEF0);
    idles(4);
    after_edge();
    chk("resync_active", {31'd0, active}, 32'd1);

    // 6. Reset mid-word
    step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h66);
    step(1'b1, 1'b0, 8'hBC);
    after_edge();
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_err", {31'd0, err_partial}, 32'd0);
    chk("mid_rst_data", data_out, 32'd0);
    idles(4);
    word(32'hCAFEBABE);
    after_edge();
    chk("w6_data", data_out, 32'hCAFEBABE);
    chk("w6_valid", {31'd0, valid_out}, 32'd1);
    idles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/deserializer_8b_32b.md
# deserializer_8b_32b

Byte-to-word deserializer forming the receive end of the 32b→8b serial link. It runs in the byte-rate domain (`clk_4f`) and accepts one byte per cycle, MSB byte first. Byte alignment comes from idle bytes (`8'hBC`) sent while the link has no valid data. It rebuilds 32-bit words, flags truncated words, and tracks link synchronization with a two-state FSM.

## Interface
- `IDLE_BYTE`, default `8'hBC`: byte value the transmitter sends while `valid_in` is low.
- `SYNC_COUNT`, default 4: number of consecutive idle bytes required to acquire sync.
- `LOSS_COUNT`, default 2: number of consecutive invalid non-idle bytes that drop sync.
- `clk_4f`, input, 1 bit: byte-rate clock. This is the only clock.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `data_in`, input, 8 bits: serial byte from the link.
- `valid_in`, input, 1 bit: `data_in` carries a payload byte.
- `data_out`, output, 32 bits: last assembled word, byte 0 in [31:24].
- `valid_out`, output, 1 bit: one-cycle pulse when a new word is on `data_out`.
- `active`, output, 1 bit: high while the FSM is in SYNC.
- `err_partial`, output, 1 bit: one-cycle pulse when a partial word is discarded.

## Operation
- **Reset** (sampled at `posedge clk_4f`), applied on the same edge:
  - state = SEARCH; `data_out` = 0; `valid_out` = 0; `active` = 0; `err_partial` = 0.
  - `byte_cnt` = 0, `idle_cnt` = 0, `bad_cnt` = 0, word buffer = 0.
  - Reset in the middle of a word discards the partial word silently (no `err_partial`).
- **Idle byte** means `valid_in` = 0 and `data_in` = `IDLE_BYTE`. **Bad byte** means `valid_in` = 0 and `data_in` ≠ `IDLE_BYTE`.
- **SEARCH state:**
  - Each idle byte increments `idle_cnt`. Any other byte, valid or bad, clears `idle_cnt`. Valid bytes are ignored and no word is assembled.
  - When the `SYNC_COUNT`-th consecutive idle byte is sampled, the next state is SYNC, and `byte_cnt` and `bad_cnt` are cleared.
  - `idle_cnt` saturates at `SYNC_COUNT`.
- **SYNC state, valid byte:**
  - Byte k (k = `byte_cnt`) is stored in buffer bits [31-8k : 24-8k], and `byte_cnt` increments.
  - When k = 3, on the same edge: `data_out` = {buffer[31:8], `data_in`}, `valid_out` = 1, and `byte_cnt` wraps to 0.
  - `bad_cnt` is cleared.
- **SYNC state, invalid byte (idle or bad) with `byte_cnt` ≠ 0:**
  - The partial word is dropped, `byte_cnt` = 0, and `err_partial` = 1 for one cycle.
  - `data_out` is not changed.
- **SYNC state, idle byte:** `bad_cnt` is cleared. Any number of idles between words is legal.
- **SYNC state, bad byte:**
  - `bad_cnt` increments.
  - When it reaches `LOSS_COUNT`, the next state is SEARCH, `active` = 0, and `idle_cnt` = 0.
  - A bad byte arriving mid-word also pulses `err_partial` on the same edge.
- `data_out` holds its value between words. `valid_out` and `err_partial` are never high for more than one consecutive cycle from a single event.

## Timing
- All outputs are registered on `posedge clk_4f`. There are no combinational input→output paths.
- **Word latency:** the fourth byte sampled at edge N produces `data_out` and `valid_out` = 1 during cycle N→N+1.
- **Back-to-back words:** 4 valid cycles give one word, so the sustained rate is one word every 4 cycles, with `valid_out` = 1 every fourth cycle.
- **Sync acquisition:** `active` rises at the edge that samples the `SYNC_COUNT`-th consecutive idle byte. A valid byte on the very next cycle is accepted as byte 0.
- **Sync loss:** `active` falls at the edge that samples the `LOSS_COUNT`-th consecutive bad byte.
- **Reset priority:** reset overrides every other event on the same edge.

## Test plan
1. **Reset and sync acquisition.**
   - Stimulus: `reset` high for 2 cycles, then 4 idle bytes (`8'hBC`, `valid_in` = 0).
   - Required: all outputs 0 during reset; `active` rises at the 4th idle edge; `valid_out` stays 0.
2. **Word assembly and back-to-back words.**
   - Stimulus: after sync, send bytes FF FB BF FF then DD DD DD DD with `valid_in` = 1 throughout.
   - Required: `data_out` = `32'hFFFBBFFF` with a `valid_out` pulse, then exactly 4 cycles later `32'hDDDDDDDD` with a second pulse.
3. **Truncated word.**
   - Stimulus: send valid DD 00, then one idle byte, then valid DD 00 00 03.
   - Required: `err_partial` pulses at the idle byte; `data_out` keeps its previous value until `32'hDD000003` appears with `valid_out`.
4. **Gap between words.**
   - Stimulus: send 3 idle bytes between two complete words.
   - Required: no `err_partial`; `active` stays 1; both words are output correctly.
5. **Sync loss and reacquisition.**
   - Stimulus: send 2 consecutive bad bytes (`8'hAA`, `valid_in` = 0), then valid bytes, then 4 idle bytes.
   - Required: `active` falls at the 2nd bad byte; the valid bytes are ignored (no `valid_out`); `active` rises again after the 4th idle byte.
6. **Reset mid-word.**
   - Stimulus: assert `reset` after 2 valid bytes of a word.
   - Required: state returns to SEARCH and all outputs are 0; no `err_partial`; after resync, the next 4 valid bytes form a complete, correct word.
